// File: rtl/phy_pkg.sv
// Shared constants for both halves of the two-lane PHY.
// Phase values are counter states of the 8f-rate phase counter.
package phy_pkg;
  localparam int         BYTE_W        = 8;
  localparam int         NUM_LANES     = 2;
  localparam logic [7:0] IDLE_BYTE     = 8'hBC;
  localparam logic [2:0] SAMPLE0_PHASE = 3'd3;
  localparam logic [2:0] SAMPLE1_PHASE = 3'd7;
  localparam logic [2:0] LOAD_PHASE    = 3'd7;

  typedef struct packed {
    logic              vld;
    logic [BYTE_W-1:0] data;
  } byte_t;
endpackage

// File: rtl/phy_tx_if.sv
// Byte-channel inputs, sample strobes and serial lane outputs of the PHY transmitter.
interface phy_tx_if;
  import phy_pkg::*;
  logic [BYTE_W-1:0] data_in_0;
  logic              valid_in_0;
  logic [BYTE_W-1:0] data_in_1;
  logic              valid_in_1;
  logic              sample_0;
  logic              sample_1;
  logic              transfer_0;
  logic              transfer_1;

  modport master (
    output data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  sample_0, sample_1, transfer_0, transfer_1
  );
  modport slave (
    input  data_in_0, valid_in_0, data_in_1, valid_in_1,
    output sample_0, sample_1, transfer_0, transfer_1
  );
endinterface

// File: rtl/partoserial.sv
// One lane: holding slot, MSB-first shift register and idle-byte insertion.
module partoserial
  import phy_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = phy_pkg::IDLE_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              load_strobe,
  output logic              serial
);
  logic              hold_full_q, hold_full_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;

  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shreg_d     = {shreg_q[BYTE_W-2:0], 1'b0};
    if (load_strobe) begin
      shreg_d     = hold_full_q ? hold_q : IDLE_BYTE;
      hold_full_d = 1'b0;
      hold_d      = '0;
    end
    // A write on the load edge refills the slot the old byte just left.
    if (wr_en) begin
      hold_full_d = 1'b1;
      hold_d      = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shreg_q     <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shreg_q     <= shreg_d;
    end
  end

  assign serial = shreg_q[BYTE_W-1];
endmodule

// File: rtl/phy_tx.sv
// Two-lane PHY transmitter: time-multiplexes two byte channels, stripes valid
// bytes alternately across lanes and serializes each lane from one 8f clock.
module phy_tx
  import phy_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = phy_pkg::IDLE_BYTE,
  parameter int         BYTE_W    = phy_pkg::BYTE_W
) (
  input  logic     clk_8f,
  input  logic     reset_L,
  phy_tx_if.slave  bus
);
  logic [2:0]           cnt_q, cnt_d;
  byte_t                mux_q, mux_d;
  logic                 lane_sel_q, lane_sel_d;
  logic                 stripe_phase, load;
  logic [NUM_LANES-1:0] wr_en;
  logic [NUM_LANES-1:0] ser;
  logic [BYTE_W-1:0]    stripe_data;

  always_comb begin
    cnt_d        = cnt_q + 3'd1;
    stripe_phase = (cnt_q == SAMPLE0_PHASE) || (cnt_q == SAMPLE1_PHASE);
    load         = (cnt_q == LOAD_PHASE);
    mux_d        = mux_q;
    if (cnt_q == SAMPLE0_PHASE) begin
      mux_d.vld  = bus.valid_in_0;
      mux_d.data = bus.data_in_0;
    end else if (cnt_q == SAMPLE1_PHASE) begin
      mux_d.vld  = bus.valid_in_1;
      mux_d.data = bus.data_in_1;
    end
    // Stripe uses the pre-edge mux byte, i.e. the channel sampled one slot ago.
    lane_sel_d = lane_sel_q;
    wr_en      = '0;
    if (stripe_phase && mux_q.vld) begin
      wr_en[lane_sel_q] = 1'b1;
      lane_sel_d        = ~lane_sel_q;
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q      <= '0;
      mux_q      <= '0;
      lane_sel_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mux_q      <= mux_d;
      lane_sel_q <= lane_sel_d;
    end
  end

  assign stripe_data = mux_q.data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    partoserial #(.IDLE_BYTE(IDLE_BYTE)) u_lane (
      .clk         (clk_8f),
      .rst_n       (reset_L),
      .wr_en       (wr_en[i]),
      .wr_data     (stripe_data),
      .load_strobe (load),
      .serial      (ser[i])
    );
  end

  assign bus.sample_0   = (cnt_q == SAMPLE0_PHASE);
  assign bus.sample_1   = (cnt_q == SAMPLE1_PHASE);
  assign bus.transfer_0 = ser[0];
  assign bus.transfer_1 = ser[1];
endmodule

// File: tb/tb_phy_tx.sv
// Scoreboard bench for phy_tx: per-lane expected bytes are queued per f period
// as channels are sampled, and compared as each lane byte is deserialized.
module tb_phy_tx;
  logic clk_8f  = 1'b0;
  logic reset_L = 1'b0;
  phy_tx_if bus();

  phy_tx dut (.clk_8f(clk_8f), .reset_L(reset_L), .bus(bus));

  always #5 clk_8f = ~clk_8f;

  int checks = 0;
  int errors = 0;
  int k;                      // edges taken since reset release
  logic       lane_m;         // model stripe pointer
  logic [1:0] pend_has;
  logic [7:0] pend_byte [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] col [2];
  logic [7:0] got [2];
  logic [1:0] done;

  function automatic logic tx(input int l);
    return (l == 0) ? bus.transfer_0 : bus.transfer_1;
  endfunction

  function automatic void exp_push(input int l, input logic [7:0] b);
    if (l == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
  endfunction

  function automatic logic [7:0] exp_pop(input int l);
    logic [7:0] b;
    b = 8'hxx;
    if (l == 0) begin if (exp_q0.size() > 0) b = exp_q0.pop_front(); end
    else        begin if (exp_q1.size() > 0) b = exp_q1.pop_front(); end
    return b;
  endfunction

  // Model reset: period 0 on both lanes is loaded from empty slots.
  task automatic model_init();
    k = 0; lane_m = 1'b0; pend_has = '0; done = '0;
    exp_q0.delete(); exp_q1.delete();
    for (int l = 0; l < 2; l++) begin
      col[l] = '0; got[l] = '0; pend_byte[l] = '0;
      exp_push(l, 8'hBC);
    end
  endtask

  task automatic apply_reset();
    bus.valid_in_0 = 1'b0; bus.data_in_0 = '0;
    bus.valid_in_1 = 1'b0; bus.data_in_1 = '0;
    reset_L = 1'b0;
    model_init();
    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    reset_L = 1'b1;
  endtask

  // One clock: drive inputs, take the edge, update model and deserializers.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    int kp;
    kp = k;
    bus.valid_in_0 = v0; bus.data_in_0 = d0;
    bus.valid_in_1 = v1; bus.data_in_1 = d1;
    @(posedge clk_8f); #1;
    k++;
    if (kp % 8 == 3 && v0) begin
      pend_has[lane_m] = 1'b1; pend_byte[lane_m] = d0; lane_m = ~lane_m;
    end
    if (kp % 8 == 7) begin
      if (v1) begin
        pend_has[lane_m] = 1'b1; pend_byte[lane_m] = d1; lane_m = ~lane_m;
      end
      // Bytes sampled in round m are loaded at the end of round m+1.
      for (int l = 0; l < 2; l++) begin
        exp_push(l, pend_has[l] ? pend_byte[l] : 8'hBC);
        pend_has[l] = 1'b0;
      end
    end
    done = '0;
    if (kp >= 7) begin
      for (int l = 0; l < 2; l++) begin
        col[l] = {col[l][6:0], tx(l)};
        if ((kp - 7) % 8 == 7) begin done[l] = 1'b1; got[l] = col[l]; end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    bus.valid_in_0 = 1'b0; bus.data_in_0 = '0;
    bus.valid_in_1 = 1'b0; bus.data_in_1 = '0;
    reset_L = 1'b0;
    model_init();
    repeat (2) @(posedge clk_8f);
    #1;
    checks++;
    if ({bus.transfer_0, bus.transfer_1, bus.sample_0, bus.sample_1} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000",
        {bus.transfer_0, bus.transfer_1, bus.sample_0, bus.sample_1});
    end
    @(negedge clk_8f);
    reset_L = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (bus.sample_0 !== (k % 8 == 3) || bus.sample_1 !== (k % 8 == 7)) begin
        errors++; $display("FAIL reset_strobes k=%0d: got %b%b expected %b%b", k,
          bus.sample_0, bus.sample_1, (k % 8 == 3), (k % 8 == 7));
      end
      if (k <= 7) begin
        checks++;
        if ({bus.transfer_0, bus.transfer_1} !== 2'b00) begin
          errors++; $display("FAIL reset_quiet k=%0d: got %b%b expected 00", k, bus.transfer_0, bus.transfer_1);
        end
      end
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL reset_idle lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 64; c++) begin
      step(k >= 16 && k < 24, 8'hA5, 1'b0, 8'h00);
      if (k >= 32 && k < 40) begin
        bus.valid_in_0 = 1'b1; bus.data_in_0 = 8'h5A;
      end
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL single lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 72; c++) begin
      step(k < 48, 8'h11, k < 48, 8'h22);
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL back_to_back lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  task automatic test_ch1_only();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 64; c++) begin
      step(1'b0, 8'h00, k < 40, 8'h33);
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL ch1_only lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  task automatic test_comma();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 48; c++) begin
      step(k >= 8 && k < 24, (k < 16) ? 8'hBC : 8'h01, 1'b0, 8'h00);
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL comma lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 8'hFF, 1'b1, 8'hFF);
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL reset_mid_pre lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
    checks++;
    if ({bus.transfer_0, bus.transfer_1} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_busy: got %b%b expected 11", bus.transfer_0, bus.transfer_1);
    end
    #1 reset_L = 1'b0;
    #1;
    checks++;
    if ({bus.transfer_0, bus.transfer_1} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_async: got %b%b expected 00", bus.transfer_0, bus.transfer_1);
    end
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step(k < 8, 8'h5A, 1'b0, 8'h00);
      if (k <= 7) begin
        checks++;
        if ({bus.transfer_0, bus.transfer_1} !== 2'b00) begin
          errors++; $display("FAIL reset_mid_quiet k=%0d: got %b%b expected 00", k, bus.transfer_0, bus.transfer_1);
        end
      end
      for (int l = 0; l < 2; l++) if (done[l]) begin
        e = exp_pop(l); checks++;
        if (got[l] !== e) begin errors++; $display("FAIL reset_mid_post lane%0d: got %h expected %h", l, got[l], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ch1_only();
    test_comma();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
